// File: rtl/rvtu_mem_rr_arb_if.sv
// Bundle of the requester-side and cache-side signals of the shared memory port.
// The arbiter uses the slave view; requesters and the cache together form the master view.
interface rvtu_mem_rr_arb_if #(
  parameter int N_REQ = 4
);
  logic [32*N_REQ-1:0] r_maddr;
  logic [N_REQ-1:0]    r_mrd;
  logic [4*N_REQ-1:0]  r_mwr;
  logic [32*N_REQ-1:0] r_mwdata;
  logic [N_REQ-1:0]    r_mresp;
  logic [31:0]         r_mrdata;
  logic [31:0]         c_maddr;
  logic                c_mrd;
  logic [3:0]          c_mwr;
  logic [31:0]         c_mwdata;
  logic                c_mresp;
  logic [31:0]         c_mrdata;

  modport slave (
    input  r_maddr, r_mrd, r_mwr, r_mwdata, c_mresp, c_mrdata,
    output r_mresp, r_mrdata, c_maddr, c_mrd, c_mwr, c_mwdata
  );

  modport master (
    output r_maddr, r_mrd, r_mwr, r_mwdata, c_mresp, c_mrdata,
    input  r_mresp, r_mrdata, c_maddr, c_mrd, c_mwr, c_mwdata
  );
endinterface

// File: rtl/rvtu_mem_rr_arb.sv
// Round-robin arbiter sharing one cache port among N_REQ requesters, one transaction
// outstanding at a time, with a sticky watchdog flag for a cache that never answers.
module rvtu_mem_rr_arb #(
  parameter int  N_REQ   = 4,
  parameter int  TIMEOUT = 1023,
  localparam int OW      = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  rvtu_mem_rr_arb_if.slave    bus,
  output logic                busy,
  output logic [OW-1:0]       owner,
  output logic                err
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [N_REQ-1:0]    w_req;
  logic [N_REQ-1:0]    w_rot;
  logic                w_any;
  logic [OW-1:0]       w_off;
  logic [OW+1:0]       w_sum;
  logic [OW-1:0]       w_win;
  logic                w_grant;
  logic [OW-1:0]       r_owner;
  logic [OW-1:0]       r_last_grant;
  logic [31:0]         r_cmd_addr;
  logic [31:0]         r_cmd_wdata;
  logic                r_cmd_rd;
  logic [3:0]          r_cmd_wr;
  logic [CW-1:0]       r_wd_cnt;
  logic                r_err;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_req[i] = bus.r_mrd[i] | (|bus.r_mwr[4*i +: 4]);
    end
  end

  // Rotate so that bit 0 is the requester just after the last grant, then take the lowest set bit.
  always_comb begin
    w_rot = N_REQ'({w_req, w_req} >> ((OW+1)'(r_last_grant) + (OW+1)'(1)));
    w_any = 1'b0;
    w_off = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!w_any && w_rot[j]) begin
        w_any = 1'b1;
        w_off = OW'(j);
      end
    end
    w_sum = (OW+2)'(r_last_grant) + (OW+2)'(1) + (OW+2)'(w_off);
    if (w_sum >= (OW+2)'(N_REQ)) begin
      w_sum = w_sum - (OW+2)'(N_REQ);
    end
    w_win = w_sum[OW-1:0];
  end

  assign w_grant = (r_state == S_IDLE) && w_any;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any)       w_next = S_BUSY;
      S_BUSY:  if (bus.c_mresp) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes drop in the completion cycle and whenever reset is asserted.
  always_comb begin
    bus.c_maddr  = r_cmd_addr;
    bus.c_mwdata = r_cmd_wdata;
    bus.c_mrd    = 1'b0;
    bus.c_mwr    = 4'b0000;
    bus.r_mresp  = '0;
    if (r_state == S_BUSY) begin
      if (!rst) begin
        bus.c_mrd = r_cmd_rd & ~bus.c_mresp;
        bus.c_mwr = r_cmd_wr & {4{~bus.c_mresp}};
      end
      bus.r_mresp[r_owner] = bus.c_mresp;
    end
  end

  assign bus.r_mrdata = bus.c_mrdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner      <= '0;
      r_last_grant <= OW'(N_REQ - 1);
      r_wd_cnt     <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_grant) begin
        r_owner  <= w_win;
        r_wd_cnt <= '0;
      end
      if (r_state == S_BUSY) begin
        if (bus.c_mresp) begin
          r_last_grant <= r_owner;
        end
        if (r_wd_cnt != CW'(TIMEOUT)) begin
          r_wd_cnt <= r_wd_cnt + CW'(1);
          if (r_wd_cnt == CW'(TIMEOUT - 1)) begin
            r_err <= 1'b1;
          end
        end
      end
    end
  end

  // Command is frozen at grant so requester changes during BUSY never reach the cache.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_cmd_addr  <= bus.r_maddr[32*w_win +: 32];
      r_cmd_wdata <= bus.r_mwdata[32*w_win +: 32];
      r_cmd_rd    <= bus.r_mrd[w_win];
      r_cmd_wr    <= bus.r_mwr[4*w_win +: 4];
    end
  end

  assign busy  = (r_state == S_BUSY);
  assign owner = r_owner;
  assign err   = r_err;

endmodule

// File: doc/rvtu_mem_rr_arb.md
RVTU_MEM_RR_ARB -- requirements
Module: rvtu_mem_rr_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the cache port (2..8).
REQ-002 Parameter TIMEOUT, default 1023, BUSY cycles without c_mresp before err is set.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 r_maddr  in  32*N_REQ  per-requester address; slice i = bits [32i+31:32i].
REQ-006 r_mrd  in  N_REQ  per-requester read request.
REQ-007 r_mwr  in  4*N_REQ  per-requester byte write enables; slice i = bits [4i+3:4i].
REQ-008 r_mwdata  in  32*N_REQ  per-requester write data.
REQ-009 r_mresp  out  N_REQ  one-cycle completion pulse to the owning requester.
REQ-010 r_mrdata  out  32  read data broadcast to all requesters, valid only with r_mresp.
REQ-011 c_maddr  out  32  cache address.
REQ-012 c_mrd  out  1  cache read strobe.
REQ-013 c_mwr  out  4  cache byte write strobes.
REQ-014 c_mwdata  out  32  cache write data.
REQ-015 c_mresp  in  1  cache completion, single-cycle pulse.
REQ-016 c_mrdata  in  32  cache read data, valid with c_mresp.
REQ-017 busy  out  1  high while a transaction is outstanding (state BUSY).
REQ-018 owner  out  $clog2(N_REQ)  index of current/last granted requester.
REQ-019 err  out  1  sticky watchdog flag.

Function
REQ-020 Requester i is "requesting" when r_mrd[i] or |r_mwr[i] is high; it holds the request stable until it sees r_mresp[i].
REQ-021 FSM has two states, IDLE and BUSY; reset state IDLE.
REQ-022 IDLE with no requesters: stay IDLE, c_mrd=0, c_mwr=0.
REQ-023 IDLE with one or more requesters: select winner by round-robin, register owner=winner, capture winner's maddr/mrd/mwr/mwdata into command registers, go to BUSY next edge.
REQ-024 Round-robin order: search from index (last_grant+1) mod N_REQ upward with wrap; first requesting index wins.
REQ-025 last_grant updates to owner on the edge where c_mresp is sampled in BUSY; reset value N_REQ-1, so requester 0 has first priority.
REQ-026 In BUSY: c_maddr and c_mwdata come from the command registers; c_mrd = cmd_mrd & ~c_mresp; c_mwr = cmd_mwr & {4{~c_mresp}}.
REQ-027 Read and write both set in the captured command: both strobes passed through unmodified.
REQ-028 In IDLE, c_maddr/c_mwdata hold the command registers; value is don't-care.
REQ-029 r_mresp[owner] = c_mresp while in BUSY, combinational; all other bits 0; r_mresp = 0 in IDLE, including if c_mresp arrives in IDLE (ignored).
REQ-030 r_mrdata = c_mrdata, combinational, all states.
REQ-031 c_mresp in BUSY returns FSM to IDLE at the next edge; a new grant is possible in that IDLE cycle, giving one idle cycle on the cache port between transactions.
REQ-032 Latency: request at cycle 0 in IDLE gives c_mrd/c_mwr at cycle 1; c_mresp at cycle k gives r_mresp at k; earliest next cache strobe at k+2.
REQ-033 Requester inputs in the cycle after its r_mresp reflect its next request; a new request from the same requester then competes at lowest round-robin priority.
REQ-034 Fairness: a continuously requesting requester is granted within N_REQ-1 other grants.
REQ-035 Requester inputs changing during BUSY do not affect c_* outputs (command registered at grant).
REQ-036 Watchdog: counter clears on entering BUSY and increments each BUSY cycle, saturating at TIMEOUT; when it reaches TIMEOUT, err sets and stays set; the transaction is not aborted.
REQ-037 busy = (state == BUSY).

Reset
REQ-038 rst high: c_mrd=0 and c_mwr=0 combinationally in that cycle, regardless of state.
REQ-039 Reset values at the next edge: state IDLE, owner 0, last_grant N_REQ-1, watchdog count 0, err 0, busy 0, r_mresp 0.
REQ-040 Reset mid-BUSY drops the outstanding transaction; a c_mresp arriving after reset is ignored per REQ-029.

Verification
REQ-041 Reset release, r_mrd=4'b1111, cache mresp 2 cycles after each strobe -> grant order 0,1,2,3,0; r_mresp one-hot per grant.
REQ-042 Only requester 2 reads addr 0x0000_1000, c_mrdata 0xDEAD_BEEF -> c_mrd high cycle 1, c_maddr 0x1000, r_mresp=4'b0100 with r_mrdata 0xDEADBEEF, c_mrd low in the mresp cycle.
REQ-043 Requester 1 write r_mwr=4'b0011, data 0x1234_5678; requester 1 changes inputs mid-BUSY -> c_mwr stays 4'b0011, c_mwdata stays 0x12345678 until c_mresp.
REQ-044 Grant requester 3, withhold c_mresp for 1023 BUSY cycles -> err=1, busy stays 1; later c_mresp -> r_mresp=4'b1000, err stays 1.
REQ-045 rst asserted in BUSY with c_mrd high -> c_mrd=0 same cycle; next cycle state IDLE, err 0; c_mresp pulse afterwards -> r_mresp=0.
REQ-046 c_mresp pulse while IDLE with no requests -> r_mresp=0, state stays IDLE.
